// File: rtl/ti_sbox_round_seq_pkg.sv
// Shared types and LFSR helper for the TI S-box round sequencer.
// No latency of its own; no backpressure.
package ti_seq_pkg;

    localparam int                LFSR_W        = 8;
    localparam logic [LFSR_W-1:0] LFSR_INIT_DEF = 8'hA5;
    localparam logic [LFSR_W-1:0] LFSR_TAPS_DEF = 8'hB8;

    typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_t;

    // Galois right-shift step; a nonzero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v,
                                                   input logic [LFSR_W-1:0] taps = LFSR_TAPS_DEF);
        return (v >> 1) ^ (v[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/ti_sbox_round_seq_if.sv
// Input/output nibble streams of the TI S-box round sequencer.
// Valid/ready on both sides; the result is held until out_ready.
interface ti_sbox_round_seq_if #(parameter int SHARE_W = 4);
    logic                   in_valid;
    logic                   in_ready;
    logic [SHARE_W-1:0]     in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*SHARE_W-1:0]   out_sh;
    logic [SHARE_W-1:0]     out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_sh, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_sh, out_data);
endinterface

// File: rtl/ti_sbox_round_seq_lfsr.sv
// Mask LFSR: 8-bit Galois generator with seed load (zero seed becomes 1) and advance enable.
// Load/advance take effect on the next clock; load beats advance in the same cycle.
// No backpressure; exposes only the low MASK_W bits that the sequencer consumes.
module ti_mask_lfsr
    import ti_seq_pkg::*;
#(
    parameter logic [LFSR_W-1:0] INIT   = LFSR_INIT_DEF,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS_DEF,
    parameter int                MASK_W = LFSR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              adv,
    output logic [MASK_W-1:0] mask
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= INIT;
        end else if (load) begin
            lfsr_q <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (adv) begin
            lfsr_q <= lfsr_next(lfsr_q, TAPS);
        end
    end

    assign mask = lfsr_q[MASK_W-1:0];

endmodule

// File: rtl/ti_sbox_round_seq.sv
// Masks a nibble into two shares and sequences the external round-1/round-2 TI LUT banks (TI_REMASK_EN: refresh shares between rounds).
// Latency: accept in cycle 0, out_valid in cycle 3; one nibble in flight, one result per 4 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, never on the release cycle.
module ti_sbox_round_seq
    import ti_seq_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_INIT_DEF,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_TAPS_DEF,
    parameter int                SHARE_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ti_sbox_round_seq_if.slave    io,
    input  logic                  seed_load,
    input  logic [LFSR_W-1:0]     seed,
    output logic [2*SHARE_W-1:0]  r1_sh,
    input  logic [2*SHARE_W-1:0]  r1_res,
    output logic [2*SHARE_W-1:0]  r2_sh,
    input  logic [2*SHARE_W-1:0]  r2_res
);

`ifdef TI_REMASK_EN
    localparam int MASK_W = LFSR_W;
    logic [SHARE_W-1:0] mhi;
`else
    localparam int MASK_W = SHARE_W;
`endif

    state_t             state;
    logic [MASK_W-1:0]  mask;
    logic               accept;

    assign io.in_ready = (state == IDLE);
    assign accept      = (state == IDLE) && io.in_valid;

    ti_mask_lfsr #(
        .INIT   (LFSR_INIT),
        .TAPS   (LFSR_TAPS),
        .MASK_W (MASK_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seed_load),
        .seed  (seed),
        .adv   (accept),
        .mask  (mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            r1_sh        <= '0;
            r2_sh        <= '0;
            io.out_sh    <= '0;
            io.out_data  <= '0;
            io.out_valid <= 1'b0;
`ifdef TI_REMASK_EN
            mhi          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        r1_sh <= {mask[SHARE_W-1:0], io.in_data ^ mask[SHARE_W-1:0]};
`ifdef TI_REMASK_EN
                        mhi   <= mask[MASK_W-1 -: SHARE_W];
`endif
                        state <= R1;
                    end
                end
                R1: begin
                    // Registering here isolates round-1 glitches from the round-2 bank.
`ifdef TI_REMASK_EN
                    r2_sh <= r1_res ^ {mhi, mhi};
`else
                    r2_sh <= r1_res;
`endif
                    state <= R2;
                end
                R2: begin
                    io.out_sh    <= r2_res;
                    io.out_data  <= r2_res[2*SHARE_W-1:SHARE_W] ^ r2_res[SHARE_W-1:0];
                    io.out_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ti_sbox_round_seq.sv
// Scoreboard bench for ti_sbox_round_seq with identity LUT banks on both rounds.
module tb_ti_sbox_round_seq;

    typedef struct packed {
        logic [7:0] sh;
        logic [3:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seed_load;
    logic [7:0] seed;
    logic [7:0] r1_sh, r1_res, r2_sh, r2_res;

    ti_sbox_round_seq_if io();

    ti_sbox_round_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (io),
        .seed_load (seed_load),
        .seed      (seed),
        .r1_sh     (r1_sh),
        .r1_res    (r1_res),
        .r2_sh     (r2_sh),
        .r2_res    (r2_res)
    );

    assign r1_res = r1_sh;
    assign r2_res = r2_sh;

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    exp_t       sb_q[$];
    logic [7:0] m_lfsr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] model_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    // seed_at: 0 none, 1 seed_load in the accept cycle, 2 seed_load during R1
    task automatic send(input logic [3:0] d, input int hold, input int seed_at, input logic [7:0] sd);
        logic [7:0] m, r1, r2;
        exp_t       e;
        int         t;
        t = 0;
        while (io.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_idle", {31'd0, io.in_ready}, 32'd1);
        m  = m_lfsr;
        r1 = {m[3:0], d ^ m[3:0]};
`ifdef TI_REMASK_EN
        r2 = r1 ^ {m[7:4], m[7:4]};
`else
        r2 = r1;
`endif
        sb_q.push_back('{sh: r2, dat: d});
        io.in_valid = 1'b1;
        io.in_data  = d;
        if (seed_at == 1) begin
            seed_load = 1'b1;
            seed      = sd;
            m_lfsr    = model_seed(sd);
        end else begin
            m_lfsr    = model_step(m_lfsr);
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        seed_load   = 1'b0;
        chk("r1_sh", {24'd0, r1_sh}, {24'd0, r1});
        chk("lfsr_after_accept", {24'd0, dut.u_lfsr.lfsr_q}, {24'd0, m_lfsr});
        chk("in_ready_busy", {31'd0, io.in_ready}, 32'd0);
        if (seed_at == 2) begin
            seed_load = 1'b1;
            seed      = sd;
            m_lfsr    = model_seed(sd);
        end
        @(negedge clk);
        seed_load = 1'b0;
        chk("r2_sh", {24'd0, r2_sh}, {24'd0, r2});
        chk("out_valid_c2", {31'd0, io.out_valid}, 32'd0);
        if (seed_at == 2)
            chk("lfsr_seed_r1", {24'd0, dut.u_lfsr.lfsr_q}, {24'd0, m_lfsr});
        @(negedge clk);
        chk("out_valid_c3", {31'd0, io.out_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        chk("out_sh", {24'd0, io.out_sh}, {24'd0, e.sh});
        chk("out_data", {28'd0, io.out_data}, {28'd0, e.dat});
        io.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, io.out_valid}, 32'd1);
            chk("hold_sh", {24'd0, io.out_sh}, {24'd0, e.sh});
            chk("hold_data", {28'd0, io.out_data}, {28'd0, e.dat});
            chk("hold_in_ready", {31'd0, io.in_ready}, 32'd0);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        chk("release_valid", {31'd0, io.out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, io.in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        seed_load    = 1'b0;
        seed         = 8'h00;
        io.in_valid  = 1'b0;
        io.in_data   = 4'h0;
        io.out_ready = 1'b0;
        m_lfsr       = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("rst_r1_sh", {24'd0, r1_sh}, 32'd0);
        chk("rst_r2_sh", {24'd0, r2_sh}, 32'd0);
        chk("rst_out_sh", {24'd0, io.out_sh}, 32'd0);
        chk("rst_out_data", {28'd0, io.out_data}, 32'd0);
        chk("rst_lfsr", {24'd0, dut.u_lfsr.lfsr_q}, 32'h0000_00A5);
        rst_n = 1'b1;
        @(negedge clk);

        send(4'h6, 0, 0, 8'h00);
        send(4'h3, 5, 0, 8'h00);

        // Zero seed is substituted by 1.
        seed_load = 1'b1;
        seed      = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr    = 8'h01;
        chk("seed_zero_lfsr", {24'd0, dut.u_lfsr.lfsr_q}, 32'h0000_0001);
        send(4'h0, 2, 0, 8'h00);

        send(4'hC, 1, 1, 8'h3C);
        send(4'h5, 0, 2, 8'h77);
        for (int i = 0; i < 6; i++)
            send(4'($urandom_range(0, 15)), $urandom_range(0, 3), 0, 8'h00);

        // Reset while in R2 drops the nibble.
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_data  = 4'h9;
        @(negedge clk);
        io.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("midrst_r2_sh", {24'd0, r2_sh}, 32'd0);
        chk("midrst_out_sh", {24'd0, io.out_sh}, 32'd0);
        chk("midrst_lfsr", {24'd0, dut.u_lfsr.lfsr_q}, 32'h0000_00A5);
        chk("midrst_in_ready", {31'd0, io.in_ready}, 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        m_lfsr = 8'hA5;
        sb_q.delete();
        @(negedge clk);
        send(4'h6, 1, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
